// File: rtl/alu_mbyte_pkg.sv
// alu_mbyte_pkg: shared definitions for the multi-byte ALU sequencer.
//   - op encodings presented on the request interface and driven to the ALU
//   - sequencer state enum
//   - bit positions inside the 3-bit C/Z/N flag vector
package alu_mbyte_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/alu_mbyte_idx.sv
// alu_mbyte_idx: byte-index counter for the multi-byte sequencer.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : advance by one; wraps to 0 after the terminal count
//   idx      : current byte index
//   tc       : high while idx == NBYTES-1
module alu_mbyte_idx #(
  parameter int NBYTES = 4,
  parameter int IDXW   = $clog2(NBYTES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [IDXW-1:0] idx,
  output logic            tc
);

  logic [IDXW-1:0] idx_reg;

  assign tc  = (idx_reg == IDXW'(NBYTES - 1));
  assign idx = idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (clr) begin
      idx_reg <= '0;
    end else if (en) begin
      idx_reg <= tc ? '0 : idx_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alu_mbyte_seq.sv
// alu_mbyte_seq: runs NBYTES-wide ADD/AND/OR (and optionally SUB) on an
// external 8-bit combinational ALU, one byte per cycle, LSB first.
// Optional feature macro: ALU_MBYTE_SUB_EN (op 11 = SUB; otherwise illegal).
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start/ready        : request handshake (accept = start & ready)
//   op, a, b, cin      : operation, operands, byte-0 carry-in (ADD only)
//   done, err          : one-cycle completion pulse, illegal-op flag
//   result, czn        : wide result and {N,Z,C}, held until next accept
//   alu_a/b/op/c, alu_busy : drive to the shared ALU, busy while owned
//   alu_result, alu_czn    : ALU outputs (only carry bit of czn is used)
module alu_mbyte_seq
  import alu_mbyte_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int IDXW   = $clog2(NBYTES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ready,
  input  logic [1:0]          op,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic                done,
  output logic                err,
  output logic [8*NBYTES-1:0] result,
  output logic [2:0]          czn,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [1:0]          alu_op,
  output logic                alu_c,
  output logic                alu_busy,
  input  logic [7:0]          alu_result,
  input  logic [2:0]          alu_czn
);

  localparam int W = 8 * NBYTES;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg, result_reg, result_next;
  logic [1:0]      op_reg;
  logic            cr_reg;
  logic [2:0]      czn_reg, flag_next;
  logic            err_reg;
  logic [IDXW-1:0] idx;
  logic            tc;
  logic            accept, legal, is_sub, running, is_add;
  logic [7:0]      a_byte [NBYTES];
  logic [7:0]      b_byte [NBYTES];

`ifdef ALU_MBYTE_SUB_EN
  assign is_sub = (op == OP_SUB);
  assign legal  = 1'b1;
`else
  assign is_sub = 1'b0;
  assign legal  = (op != OP_SUB);
`endif

  assign ready   = (state_reg != RUN);
  assign accept  = start && ready;
  assign running = (state_reg == RUN);
  // SUB is latched as ADD of ~b with carry-in 1, so is_add covers both.
  assign is_add  = (op_reg == OP_ADD);

  alu_mbyte_idx #(.NBYTES(NBYTES), .IDXW(IDXW)) u_idx (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (running),
    .idx (idx),
    .tc  (tc)
  );

  // Byte views of the latched operands and the result with the current
  // ALU byte merged in; flags on the last byte are taken from the merge.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
    assign a_byte[gi] = a_reg[8*gi +: 8];
    assign b_byte[gi] = b_reg[8*gi +: 8];
    assign result_next[8*gi +: 8] = (running && idx == IDXW'(gi)) ? alu_result
                                                                  : result_reg[8*gi +: 8];
  end

  always_comb begin
    flag_next         = '0;
    flag_next[FLAG_C] = is_add ? alu_czn[0] : 1'b0;
    flag_next[FLAG_Z] = (result_next == '0);
    flag_next[FLAG_N] = result_next[W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_op     = 2'b00;
    alu_c      = 1'b0;
    alu_busy   = 1'b0;
    case (state_reg)
      RUN: begin
        alu_a    = a_byte[idx];
        alu_b    = b_byte[idx];
        alu_op   = op_reg;
        alu_c    = is_add ? cr_reg : 1'b0;
        alu_busy = 1'b1;
        if (tc) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_next = legal ? RUN : DONE;
        else        state_next = IDLE;
      end
      default: begin
        if (accept) state_next = legal ? RUN : DONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= OP_ADD;
      cr_reg     <= 1'b0;
      result_reg <= '0;
      czn_reg    <= '0;
      err_reg    <= 1'b0;
    end else if (accept) begin
      a_reg      <= a;
      result_reg <= '0;
      czn_reg    <= '0;
      err_reg    <= !legal;
      if (is_sub) begin
        b_reg  <= ~b;
        op_reg <= OP_ADD;
        cr_reg <= 1'b1;
      end else begin
        b_reg  <= b;
        op_reg <= op;
        cr_reg <= (op == OP_ADD) ? cin : 1'b0;
      end
    end else if (running) begin
      result_reg <= result_next;
      if (is_add) cr_reg <= alu_czn[0];
      if (tc) czn_reg <= flag_next;
    end
  end

  assign result = result_reg;
  assign czn    = czn_reg;
  assign err    = err_reg;

endmodule

// File: tb/tb_alu_mbyte_seq.sv
// tb_alu_mbyte_seq: directed + randomized bench for alu_mbyte_seq (NBYTES=4)
// with a behavioural 8-bit ALU attached and a 32-bit arithmetic reference.
module tb_alu_mbyte_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, err, alu_c, alu_busy;
  logic [W-1:0] result;
  logic [2:0]   czn, alu_czn;
  logic [7:0]   alu_a, alu_b, alu_result;
  logic [1:0]   alu_op;

  always #5 clk = ~clk;

  alu_mbyte_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .op(op), .a(a), .b(b),
    .cin(cin), .done(done), .err(err), .result(result), .czn(czn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .alu_busy(alu_busy), .alu_result(alu_result), .alu_czn(alu_czn)
  );

  // Behavioural ALU; Z/N bits (and carry outside ADD) are junk on purpose.
  logic [8:0] alu_sum;
  logic [1:0] junk = 2'b00;
  always @(posedge clk) junk <= 2'($urandom);
  always_comb begin
    alu_sum = 9'(alu_a) + 9'(alu_b) + 9'(alu_c);
    case (alu_op)
      2'b00:   alu_result = alu_sum[7:0];
      2'b01:   alu_result = alu_a & alu_b;
      2'b10:   alu_result = alu_a | alu_b;
      default: alu_result = 8'h00;
    endcase
    alu_czn = {junk, (alu_op == 2'b00) ? alu_sum[8] : junk[0]};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic c, output logic [W-1:0] r, output logic [2:0] f,
                                output logic e, output int lat);
    logic [W:0] s;
    e = 1'b0; lat = NB + 1; s = '0; f = 3'b000;
    case (o)
      2'b00: s = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      2'b01: s = {1'b0, x & y};
      2'b10: s = {1'b0, x | y};
      default: begin
`ifdef ALU_MBYTE_SUB_EN
        s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
`else
        e = 1'b1; lat = 1;
`endif
      end
    endcase
    r = s[W-1:0];
    if (!e) f = {r[W-1], (r == '0), s[W]};
  endfunction

  // Called at a negedge; returns at the negedge of cycle T+1.
  task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    op = o; a = x; b = y; cin = c; start = 1'b1;
    check("ready_at_start", 64'(ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input bit inject, input bit b2b);
    logic [W-1:0] er, ybyte_src;
    logic [2:0]   ef;
    logic         ee, seen;
    int           lat, k, busy;
    model(o, x, y, c, er, ef, ee, lat);
    ybyte_src = (o == 2'b11) ? ~y : y;
    k = 1; busy = 0; seen = 1'b0;
    while (k <= 20) begin
      if (inject && k == 2) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 2'b01; cin = ~c;
      end
      if (inject && k == 3) start = 1'b0;
      if (alu_busy) begin
        busy++;
        if (k <= NB) begin
          check("alu_a_byte", 64'(alu_a), 64'(x[8*(k-1) +: 8]));
          check("alu_b_byte", 64'(alu_b), 64'(ybyte_src[8*(k-1) +: 8]));
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(k), 64'(lat));
    check("busy_cycles", 64'(busy), 64'(lat - 1));
    check("result", 64'(result), 64'(er));
    check("czn", 64'(czn), 64'(ef));
    check("err", 64'(err), 64'(ee));
    check("done_alu_idle", {53'd0, alu_a, alu_b, alu_busy}, 64'd0);
    $display("txn op=%0d a=%08h b=%08h cin=%0d -> result=%08h czn=%03b err=%0d lat=%0d",
             o, x, y, c, result, czn, err, k);
    if (!b2b) begin
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_alu", {52'd0, alu_a, alu_b, alu_op, alu_c, alu_busy}, 64'd0);
      check("result_held", 64'(result), 64'(er));
    end
  endtask

  task automatic txn(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    send(o, x, y, c);
    collect(o, x, y, c, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_czn", 64'(czn), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(alu_busy), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    txn(2'b00, 32'h000000FF, 32'h00000001, 1'b0);
    txn(2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    txn(2'b00, 32'hFFFFFFFF, 32'h00000000, 1'b1);

    send(2'b01, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1);
    collect(2'b01, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b1);
    send(2'b10, 32'h80000000, 32'h00000001, 1'b0);
    collect(2'b10, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0);

    send(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    collect(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the second RUN cycle.
    send(2'b00, 32'h11111111, 32'h22222222, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_czn", 64'(czn), 64'd0);
    check("arst_busy", 64'(alu_busy), 64'd0);
    check("arst_alu_a", 64'(alu_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    check("arst_no_done", 64'(done), 64'd0);
    txn(2'b00, 32'h0000FFFF, 32'h00000001, 1'b0);

    txn(2'b11, 32'h00000005, 32'h00000007, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
      txn(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
